// File: rtl/operand_stage_pkg.sv
// Shared definitions for the operand stage: default sizes, the register
// address type, the control-bundle type and a range-check helper.
package operand_stage_pkg;

  localparam int unsigned NREGS_DEF = 13;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned CTRLW_DEF = 16;
  localparam int unsigned ADDRW     = 4;

  typedef logic [ADDRW-1:0]     reg_addr_t;
  typedef logic [CTRLW_DEF-1:0] ctrl_t;

  // True when the address names a tracked architectural register.
  function automatic logic addr_in_range(input reg_addr_t addr, input int unsigned nregs);
    return (32'(addr) < nregs);
  endfunction

endpackage

// File: rtl/operand_bypass_mux.sv
// Per-source operand select: out-of-range address reads as zero, a matching
// writeback (when OPERAND_BYPASS_EN is defined) forwards wb_data, otherwise
// the register file read data is used.
// Ports:
//   addr, rdata                 - source address and its register file data
//   wb_en, wb_addr, wb_data     - writeback port
//   hit_c                       - writeback forwarded to this source
//   operand_c                   - selected operand
// Configuration: OPERAND_BYPASS_EN enables the writeback forwarding path.
module operand_bypass_mux
  import operand_stage_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned XLEN  = XLEN_DEF
) (
  input  reg_addr_t         addr,
  input  logic [XLEN-1:0]   rdata,
  input  logic              wb_en,
  input  reg_addr_t         wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              hit_c,
  output logic [XLEN-1:0]   operand_c
);

  logic in_range_c;

`ifdef OPERAND_BYPASS_EN
  assign hit_c = in_range_c & wb_en & (wb_addr == addr);
`else
  logic unused_wb_c;
  assign unused_wb_c = ^{wb_en, wb_addr, wb_data};
  assign hit_c       = 1'b0;
`endif

  always_comb begin
    in_range_c = addr_in_range(addr, NREGS);
    operand_c  = '0;
    if (!in_range_c) begin
      operand_c = '0;
`ifdef OPERAND_BYPASS_EN
    end else if (hit_c) begin
      operand_c = wb_data;
`endif
    end else begin
      operand_c = rdata;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// Operand fetch pipeline stage with a register scoreboard. Latches three
// operands plus destination/control for one instruction, stalls on RAW/WAW
// hazards against in-flight writers, and clears scoreboard bits on writeback.
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   in_valid/in_ready           - upstream handshake (in_ready is combinational)
//   a1..a3, r1..r3              - source addresses and register file data
//   in_regwrite, in_ctrl        - destination write flag, opaque control bundle
//   flush                       - kill the held instruction
//   wb_en, wb_addr, wb_data     - writeback port
//   out_valid/out_ready         - downstream handshake
//   out_opa/opb/opc, out_dest, out_regwrite, out_ctrl - held instruction
// Configuration: OPERAND_BYPASS_EN enables writeback forwarding into operands.
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CTRLW = CTRLW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  reg_addr_t         a1,
  input  reg_addr_t         a2,
  input  reg_addr_t         a3,
  input  logic [XLEN-1:0]   r1,
  input  logic [XLEN-1:0]   r2,
  input  logic [XLEN-1:0]   r3,
  input  logic              in_regwrite,
  input  logic [CTRLW-1:0]  in_ctrl,
  input  logic              flush,
  input  logic              wb_en,
  input  reg_addr_t         wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_opa,
  output logic [XLEN-1:0]   out_opb,
  output logic [XLEN-1:0]   out_opc,
  output reg_addr_t         out_dest,
  output logic              out_regwrite,
  output logic [CTRLW-1:0]  out_ctrl
);

  logic [XLEN-1:0]  opa_c, opb_c, opc_c;
  logic [2:0]       hit_c;
  reg_addr_t        src_c [3];
  logic             hazard_c, accept_c, issue_c;

  logic             out_valid_q, out_valid_d;
  logic             out_regwrite_q, out_regwrite_d;
  logic [XLEN-1:0]  out_opa_q, out_opa_d;
  logic [XLEN-1:0]  out_opb_q, out_opb_d;
  logic [XLEN-1:0]  out_opc_q, out_opc_d;
  reg_addr_t        out_dest_q, out_dest_d;
  logic [CTRLW-1:0] out_ctrl_q, out_ctrl_d;
  logic [NREGS-1:0] pending_q, pending_d;

  operand_bypass_mux #(.NREGS(NREGS), .XLEN(XLEN)) u_mux_a (
    .addr(a1), .rdata(r1), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .hit_c(hit_c[0]), .operand_c(opa_c)
  );
  operand_bypass_mux #(.NREGS(NREGS), .XLEN(XLEN)) u_mux_b (
    .addr(a2), .rdata(r2), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .hit_c(hit_c[1]), .operand_c(opb_c)
  );
  operand_bypass_mux #(.NREGS(NREGS), .XLEN(XLEN)) u_mux_c (
    .addr(a3), .rdata(r3), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .hit_c(hit_c[2]), .operand_c(opc_c)
  );

  // Hazard: an in-range source is pending without a forwarding hit, or it
  // matches the destination of the writer currently held in this stage.
  always_comb begin
    src_c[0] = a1;
    src_c[1] = a2;
    src_c[2] = a3;
    hazard_c = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (src_c[s] == ADDRW'(i)) begin
          if ((pending_q[i] && !hit_c[s]) ||
              (out_valid_q && out_regwrite_q && (out_dest_q == src_c[s]))) begin
            hazard_c = 1'b1;
          end
        end
      end
    end
  end

  assign in_ready = (~out_valid_q | out_ready) & ~hazard_c & ~flush;
  assign accept_c = in_valid & in_ready;
  assign issue_c  = out_valid_q & out_ready;

  // Scoreboard: writeback clears first so a same-cycle issue set wins.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (wb_en && (wb_addr == ADDRW'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (issue_c && out_regwrite_q && (out_dest_q == ADDRW'(i))) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  // Output register: load on accept, drop valid on issue or flush, else hold.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_regwrite_d = out_regwrite_q;
    out_opa_d      = out_opa_q;
    out_opb_d      = out_opb_q;
    out_opc_d      = out_opc_q;
    out_dest_d     = out_dest_q;
    out_ctrl_d     = out_ctrl_q;
    if (accept_c) begin
      out_valid_d    = 1'b1;
      out_regwrite_d = in_regwrite;
      out_opa_d      = opa_c;
      out_opb_d      = opb_c;
      out_opc_d      = opc_c;
      out_dest_d     = a3;
      out_ctrl_d     = in_ctrl;
    end else if (issue_c || flush) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q    <= 1'b0;
      out_regwrite_q <= 1'b0;
      out_opa_q      <= '0;
      out_opb_q      <= '0;
      out_opc_q      <= '0;
      out_dest_q     <= '0;
      out_ctrl_q     <= '0;
      pending_q      <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_regwrite_q <= out_regwrite_d;
      out_opa_q      <= out_opa_d;
      out_opb_q      <= out_opb_d;
      out_opc_q      <= out_opc_d;
      out_dest_q     <= out_dest_d;
      out_ctrl_q     <= out_ctrl_d;
      pending_q      <= pending_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_regwrite = out_regwrite_q;
  assign out_opa      = out_opa_q;
  assign out_opb      = out_opb_q;
  assign out_opc      = out_opc_q;
  assign out_dest     = out_dest_q;
  assign out_ctrl     = out_ctrl_q;

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter NREGS, default 13: number of architectural registers tracked (addresses 0..NREGS-1).
REQ-002 Parameter XLEN, default 32: operand/data width.
REQ-003 Parameter CTRLW, default 16: width of the opaque control bundle carried alongside operands.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  upstream instruction present.
REQ-007 in_ready  out  1  stage accepts an instruction this cycle.
REQ-008 a1, a2, a3  in  4 each  source addresses (a3 is also the destination), driven to register file A1/A2/A3.
REQ-009 r1, r2, r3  in  XLEN each  register file read data for a1/a2/a3.
REQ-010 in_regwrite  in  1  instruction writes register a3.
REQ-011 in_ctrl  in  CTRLW  control bundle, passed through unmodified.
REQ-012 flush  in  1  kill held instruction.
REQ-013 wb_en, wb_addr, wb_data  in  1/4/XLEN  writeback port, same values as register file RegWrite/A3/WD3.
REQ-014 out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-015 out_opa, out_opb, out_opc  out  XLEN each  latched operands for a1/a2/a3.
REQ-016 out_dest  out  4; out_regwrite  out  1; out_ctrl  out  CTRLW.

Function
REQ-017 Accept = in_valid & in_ready; issue = out_valid & out_ready.
REQ-018 in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
REQ-019 On accept, all outputs load within one cycle (latency 1); otherwise, if issue occurs, out_valid clears; otherwise all outputs hold.
REQ-020 Operand select per source x: address >= NREGS -> 0; else bypass hit (wb_en & wb_addr==ax) -> wb_data; else rx.
REQ-021 Scoreboard pending[NREGS]: bit out_dest sets on issue when out_regwrite and out_dest<NREGS; bit wb_addr clears when wb_en; set wins when both hit same bit in one cycle.
REQ-022 hazard = any source ax<NREGS with (pending[ax] & ~bypass hit) or (out_valid & out_regwrite & out_dest==ax).
REQ-023 Addresses >= NREGS never set pending and never cause hazard.
REQ-024 flush clears out_valid on the next edge and blocks accept that cycle; pending bits unaffected; flush overrides a simultaneous issue's data but issue, if it fires, still updates the scoreboard.
REQ-025 out_valid, once set, holds with stable payload until issue or flush.

Reset
REQ-026 While rst low: out_valid=0, out_regwrite=0, pending=0, out_opa/opb/opc=0, out_dest=0, out_ctrl=0; in_ready evaluates combinationally from cleared state.
REQ-027 Reset mid-operation discards the held instruction and all pending bits; no partial state survives.

Configuration
REQ-028 Macro OPERAND_BYPASS_EN: defined -> REQ-020 bypass path and its hazard exemption active.
REQ-029 Undefined -> operand is always rx (or 0 for out-of-range), and pending[ax] stalls regardless of writeback; the read succeeds the cycle after wb clears the bit.

Structure
REQ-030 Shared package holds NREGS/XLEN/CTRLW defaults, register-address typedef (4 bit) and control-bundle typedef.
REQ-031 One sub-module, operand_bypass_mux: combinational per-source select of REQ-020, instantiated three times.

Verification
REQ-032 Reset, then a1=1,a2=2,r1=5,r2=7, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_opa=5, out_opb=7.
REQ-033 Issue writer to dest 3, next instruction reads a1=3 with wb idle -> in_ready=0 until wb_en,wb_addr=3,wb_data=0xAB; with OPERAND_BYPASS_EN accepted that cycle with out_opa=0xAB; without, accepted one cycle later.
REQ-034 out_ready=0 for 4 cycles with held valid -> out_* stable, in_ready=0; release -> single issue.
REQ-035 flush asserted with out_valid=1 -> out_valid=0 next cycle, pending unchanged.
REQ-036 a1=14 with r1=0xFFFF -> out_opa=0, no stall; same-cycle issue to dest 3 and wb clear of 3 -> pending[3]=1.
